// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and state encoding for the EX-stage hazard controller
//
// Purpose : forwarding-select encoding (shared with the datapath forwarding_mux),
//           controller state encoding and the default register address width.
// Ports   : none (package).
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // Operand source selects for the EX-stage forwarding mux; 2'b11 is never driven.
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN        = 2'd0;
  localparam state_t ST_LOAD_STALL = 2'd1;
  localparam state_t ST_FLUSH      = 2'd2;

endpackage

// File: rtl/hazard_ctrl_fwd_sel_calc.sv
// rtl/hazard_ctrl_fwd_sel_calc.sv - combinational forwarding select for one ID-stage source operand
//
// Purpose : picks where the operand of the instruction in ID should come from once
//           it reaches EX. The producer currently in EX will be in MEM by then (01),
//           the producer currently in MEM will be in WB (10).
// Ports   : rs_addr                     - source register of the ID instruction
//           ex_rd_addr / ex_reg_write   - destination of the instruction in EX
//           mem_rd_addr / mem_reg_write - destination of the instruction in MEM
//           fwd_sel                     - resulting select (FWD_* encoding)
module fwd_sel_calc #(
  parameter int REG_ADDR_W = hazard_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  output logic [1:0]            fwd_sel
);
  import hazard_ctrl_pkg::*;

  // The younger producer (EX) wins; x0 is hard-wired zero and never forwarded.
  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (ex_reg_write && (ex_rd_addr != '0) && (ex_rd_addr == rs_addr)) begin
      fwd_sel = FWD_MEM;
    end else if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - execute-stage hazard, forwarding and flush sequencing controller
//
// Purpose : registers forwarding selects for the instruction entering EX, inserts a
//           single bubble on a load-use hazard, sequences branch flushes and freezes
//           the front end on an external data-memory stall.
// Ports   : clk, rst (sync, active high)
//           id_*              - source operands of the instruction in ID
//           ex_*, mem_*       - destinations of the instructions in EX and MEM
//           branch_taken_in   - registered branch-taken from EX
//           ext_stall_in      - data memory not ready
//           forward_a/b_out   - registered operand selects (valid while the instruction is in EX)
//           pc_stall_out, ifid_stall_out, idex_bubble_out            - combinational stall controls
//           ifid_flush_out, idex_flush_out, exmem_flush_out          - combinational flush controls
//           stall_cycles_out, flush_events_out - saturating perf counters, present only
//                                                when HAZARD_PERF_CNT_EN is defined
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_ADDR_W   = hazard_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic                  branch_taken_in,
  input  logic                  ext_stall_in,
  output logic [1:0]            forward_a_out,
  output logic [1:0]            forward_b_out,
  output logic                  pc_stall_out,
  output logic                  ifid_stall_out,
  output logic                  idex_bubble_out,
  output logic                  ifid_flush_out,
  output logic                  idex_flush_out,
  output logic                  exmem_flush_out
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles_out,
  output logic [31:0]           flush_events_out
`endif
);
  import hazard_ctrl_pkg::*;

  // Counter holds at most FLUSH_CYCLES-1.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t           state_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [1:0]       fwd_a_calc;
  logic [1:0]       fwd_b_calc;
  logic             load_use;
  logic             flush_start;

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_addr       (id_rs1_addr),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .fwd_sel       (fwd_a_calc)
  );

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_addr       (id_rs2_addr),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .fwd_sel       (fwd_b_calc)
  );

  always_comb begin
    load_use = ex_mem_read && (ex_rd_addr != '0) &&
               ((id_uses_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));
  end

  // Stall/flush controls. Reset outranks everything, so outputs are quiet while rst is high.
  // In LOAD_STALL the bubble has already been issued, so load-use is not re-evaluated there.
  always_comb begin
    pc_stall_out    = 1'b0;
    ifid_stall_out  = 1'b0;
    idex_bubble_out = 1'b0;
    ifid_flush_out  = 1'b0;
    idex_flush_out  = 1'b0;
    exmem_flush_out = 1'b0;
    flush_start     = 1'b0;
    if (!rst) begin
      if (state_q == ST_FLUSH) begin
        ifid_flush_out  = 1'b1;
        idex_flush_out  = 1'b1;
        exmem_flush_out = 1'b1;
      end else if (branch_taken_in) begin
        ifid_flush_out  = 1'b1;
        idex_flush_out  = 1'b1;
        exmem_flush_out = 1'b1;
        flush_start     = 1'b1;
      end else if (ext_stall_in) begin
        pc_stall_out    = 1'b1;
        ifid_stall_out  = 1'b1;
      end else if ((state_q == ST_RUN) && load_use) begin
        pc_stall_out    = 1'b1;
        ifid_stall_out  = 1'b1;
        idex_bubble_out = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= '0;
      forward_a_out <= FWD_REGFILE;
      forward_b_out <= FWD_REGFILE;
    end else if (state_q == ST_FLUSH) begin
      // Flushed slots carry no operands.
      forward_a_out <= FWD_REGFILE;
      forward_b_out <= FWD_REGFILE;
      if (!ext_stall_in) begin
        if (flush_cnt_q <= CNT_W'(1)) begin
          flush_cnt_q <= '0;
          state_q     <= ST_RUN;
        end else begin
          flush_cnt_q <= flush_cnt_q - CNT_W'(1);
        end
      end
    end else if (branch_taken_in) begin
      forward_a_out <= FWD_REGFILE;
      forward_b_out <= FWD_REGFILE;
      flush_cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
      state_q       <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (ext_stall_in) begin
      // Frozen: forward selects, state and counter all hold.
    end else if ((state_q == ST_RUN) && load_use) begin
      forward_a_out <= FWD_REGFILE;
      forward_b_out <= FWD_REGFILE;
      state_q       <= ST_LOAD_STALL;
    end else begin
      // In LOAD_STALL the load has moved to MEM, so the consumer now resolves to WB.
      forward_a_out <= fwd_a_calc;
      forward_b_out <= fwd_b_calc;
      state_q       <= ST_RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_out <= '0;
      flush_events_out <= '0;
    end else begin
      if (pc_stall_out && (stall_cycles_out != 32'hFFFF_FFFF)) begin
        stall_cycles_out <= stall_cycles_out + 32'd1;
      end
      if (flush_start && (flush_events_out != 32'hFFFF_FFFF)) begin
        flush_events_out <= flush_events_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, mem_reg_write;
  logic       branch_taken_in, ext_stall_in;
  logic [1:0] forward_a_out, forward_b_out;
  logic       pc_stall_out, ifid_stall_out, idex_bubble_out;
  logic       ifid_flush_out, idex_flush_out, exmem_flush_out;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_out, flush_events_out;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd_addr      (ex_rd_addr),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .mem_rd_addr     (mem_rd_addr),
    .mem_reg_write   (mem_reg_write),
    .branch_taken_in (branch_taken_in),
    .ext_stall_in    (ext_stall_in),
    .forward_a_out   (forward_a_out),
    .forward_b_out   (forward_b_out),
    .pc_stall_out    (pc_stall_out),
    .ifid_stall_out  (ifid_stall_out),
    .idex_bubble_out (idex_bubble_out),
    .ifid_flush_out  (ifid_flush_out),
    .idex_flush_out  (idex_flush_out),
    .exmem_flush_out (exmem_flush_out)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_out (stall_cycles_out),
    .flush_events_out (flush_events_out)
`endif
  );

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       bubble;
    logic       flush;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [1:0] act, input logic [1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %b expected %b", nm, fld, act, req);
    end
  endtask

  // One vector per cycle: inputs applied just after the rising edge, expected outputs
  // for that same cycle queued for the monitor.
  task automatic step(input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] exrd, input logic exw, input logic exmr,
                      input logic [4:0] memrd, input logic memw,
                      input logic br, input logic st,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic stall, input logic bubble, input logic flush,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd_addr = exrd; ex_reg_write = exw; ex_mem_read = exmr;
    mem_rd_addr = memrd; mem_reg_write = memw;
    branch_taken_in = br; ext_stall_in = st;
    e.fa = fa; e.fb = fb; e.stall = stall; e.bubble = bubble; e.flush = flush;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: the DUT presents a full output set every cycle; sample mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "forward_a",   forward_a_out,          e.fa);
        chk(nm, "forward_b",   forward_b_out,          e.fb);
        chk(nm, "pc_stall",    {1'b0, pc_stall_out},    {1'b0, e.stall});
        chk(nm, "ifid_stall",  {1'b0, ifid_stall_out},  {1'b0, e.stall});
        chk(nm, "idex_bubble", {1'b0, idex_bubble_out}, {1'b0, e.bubble});
        chk(nm, "ifid_flush",  {1'b0, ifid_flush_out},  {1'b0, e.flush});
        chk(nm, "idex_flush",  {1'b0, idex_flush_out},  {1'b0, e.flush});
        chk(nm, "exmem_flush", {1'b0, exmem_flush_out}, {1'b0, e.flush});
      end
    end
  end

  initial begin
    rst = 1'b1;
    id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd_addr = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd_addr = '0; mem_reg_write = 1'b0;
    branch_taken_in = 1'b0; ext_stall_in = 1'b0;
    repeat (2) @(posedge clk);

    //    r rs1 rs2 u1 u2 exrd w mr memrd w br st  fa fb  stl bub fl  name
    step(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, "reset");
    // add x5 in EX, sub x6,x5,x3 in ID
    step(0, 5, 3, 1, 1,  5, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, "add_sub_id");
    step(0, 0, 0, 0, 0,  6, 1, 0,  5, 1, 0, 0, 1, 0,  0, 0, 0, "add_sub_ex");
    // lw x7 in EX, add x8,x7,x7 in ID
    step(0, 7, 7, 1, 1,  7, 1, 1,  6, 1, 0, 0, 0, 0,  1, 1, 0, "load_use_stall");
    step(0, 7, 7, 1, 1,  0, 0, 0,  7, 1, 0, 0, 0, 0,  0, 0, 0, "load_stall_state");
    step(0, 0, 0, 0, 0,  8, 1, 0,  0, 0, 0, 0, 2, 2,  0, 0, 0, "load_use_fwd_wb");
    // writes to x0 then read of x0
    step(0, 0, 0, 1, 1,  0, 1, 0,  0, 1, 0, 0, 0, 0,  0, 0, 0, "x0_id");
    step(0, 3, 3, 0, 0,  3, 1, 0,  3, 1, 0, 0, 0, 0,  0, 0, 0, "x0_ex");
    // EX match outranks MEM match
    step(0, 9, 3, 0, 0,  3, 1, 0,  9, 1, 0, 0, 1, 1,  0, 0, 0, "ex_priority");
    step(0, 0, 0, 0, 0,  3, 0, 0,  0, 0, 0, 0, 2, 1,  0, 0, 0, "mixed_sel");
    step(0, 4, 4, 0, 0,  4, 0, 0,  4, 1, 0, 0, 0, 0,  0, 0, 0, "ex_no_write_id");
    // branch with a simultaneous load-use, FLUSH_CYCLES=2
    step(0, 7, 0, 1, 0,  7, 1, 1,  0, 0, 1, 0, 2, 2,  0, 0, 1, "branch_with_load_use");
    step(0, 7, 0, 1, 0,  7, 1, 1,  0, 0, 1, 0, 0, 0,  0, 0, 1, "flush_hold");
    step(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, "flush_done");
    // external stall held 3 cycles over a load-use
    step(0, 5, 6, 1, 1,  5, 1, 0,  6, 1, 0, 0, 0, 0,  0, 0, 0, "pre_ext_stall");
    step(0, 7, 2, 1, 1,  7, 1, 1,  0, 0, 0, 1, 1, 2,  1, 0, 0, "ext_stall_1");
    step(0, 7, 2, 1, 1,  7, 1, 1,  0, 0, 0, 1, 1, 2,  1, 0, 0, "ext_stall_2");
    step(0, 7, 2, 1, 1,  7, 1, 1,  0, 0, 0, 1, 1, 2,  1, 0, 0, "ext_stall_3");
    step(0, 7, 2, 1, 1,  7, 1, 1,  0, 0, 0, 0, 1, 2,  1, 1, 0, "bubble_after_ext");
    step(0, 7, 2, 1, 1,  0, 0, 0,  7, 1, 0, 0, 0, 0,  0, 0, 0, "load_stall_after_ext");
    step(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 2, 0,  0, 0, 0, "fwd_after_ext");
    // reset while in LOAD_STALL
    step(0, 7, 7, 1, 1,  7, 1, 1,  0, 0, 0, 0, 0, 0,  1, 1, 0, "lu_before_rst");
    step(1, 7, 7, 1, 1,  0, 0, 0,  7, 1, 0, 0, 0, 0,  0, 0, 0, "rst_in_load_stall");
    step(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, "after_rst_load_stall");
    // reset mid-FLUSH (branch taken from LOAD_STALL)
    step(0, 7, 7, 1, 1,  7, 1, 1,  0, 0, 0, 0, 0, 0,  1, 1, 0, "run_after_rst");
    step(0, 0, 0, 0, 0,  0, 0, 0,  7, 1, 1, 0, 0, 0,  0, 0, 1, "branch_in_load_stall");
    step(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, "rst_mid_flush");
    step(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, "after_rst_flush");
    step(0, 7, 7, 1, 1,  7, 1, 1,  0, 0, 0, 0, 0, 0,  1, 1, 0, "run_after_rst_flush");

    begin
      int wait_cycles;
      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
        @(posedge clk);
        wait_cycles++;
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
